// File: rtl/conv_maxpool2x2_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic conv pipeline and its pooling stage.
//   calc_res_w   : conv result width derived from the pixel/weight width
//   pool_state_t : row-phase encoding used by conv_maxpool2x2
// -----------------------------------------------------------------------------
package systolic_pkg;

    function automatic int calc_res_w(input int data_size);
        return 2 * data_size + 5;
    endfunction

    localparam int RES_W_DEFAULT = calc_res_w(8);

    typedef enum logic [1:0] {
        EVEN_ROW = 2'd0,
        ODD_ROW  = 2'd1,
        DROP_ROW = 2'd2
    } pool_state_t;

endpackage

// File: rtl/conv_maxpool2x2_if.sv
// -----------------------------------------------------------------------------
// conv_maxpool2x2_if
// Stream bundle between the conv result producer and the 2x2 max-pool stage.
//   in_valid / in_data     : one signed conv result per asserted cycle
//   pool_valid / pool_data : one-cycle pulse with the pooled maximum
//   frame_done             : one-cycle pulse after the last conv result
//   pool_count             : pooled values emitted in the current frame
// master = producer/consumer side, slave = pooling block.
// -----------------------------------------------------------------------------
interface conv_maxpool2x2_if
    import systolic_pkg::*;
#(
    parameter int RES_W = RES_W_DEFAULT
);
    logic                    in_valid;
    logic signed [RES_W-1:0] in_data;
    logic                    pool_valid;
    logic signed [RES_W-1:0] pool_data;
    logic                    frame_done;
    logic [15:0]             pool_count;

    modport master (
        output in_valid, in_data,
        input  pool_valid, pool_data, frame_done, pool_count
    );

    modport slave (
        input  in_valid, in_data,
        output pool_valid, pool_data, frame_done, pool_count
    );
endinterface

// File: rtl/conv_maxpool2x2_linebuf.sv
// -----------------------------------------------------------------------------
// pool_linebuf
// Single-port register array holding the pair maxima of the last even row.
//   clk, rst : clock, synchronous active-high reset (clears read register only)
//   i_we     : write i_wdata to entry i_addr
//   i_re     : load entry i_addr into the read register (visible next cycle)
//   o_rdata  : registered read data, held between reads
// -----------------------------------------------------------------------------
module pool_linebuf #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 1,
    parameter int AW    = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Contents need no reset: every entry is rewritten on each even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/conv_maxpool2x2.sv
// -----------------------------------------------------------------------------
// conv_maxpool2x2
// 2x2 stride-2 max pooling over a raster-ordered conv result stream.
//   clk, rst : clock, synchronous active-high reset
//   pool_if  : conv_maxpool2x2_if.slave (in_valid/in_data in,
//              pool_valid/pool_data/frame_done/pool_count out)
// Build option: POOL_RELU_EN clamps negative inputs to 0 before pooling.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// EVEN_ROW | pair maxima written to the line buffer
// ODD_ROW  | pair maxima combined with line buffer, pooled value emitted
// DROP_ROW | trailing row of an odd-height map, counted and discarded
// -----------------------------------------------------------------------------
module conv_maxpool2x2
    import systolic_pkg::*;
#(
    parameter int dataSize   = 8,
    parameter int IMG_WIDTH  = 3,
    parameter int IMG_HEIGHT = 3
)(
    input  logic               clk,
    input  logic               rst,
    conv_maxpool2x2_if.slave   pool_if
);
    localparam int RES_W    = calc_res_w(dataSize);
    localparam int CW       = IMG_WIDTH - 1;
    localparam int CH       = IMG_HEIGHT - 1;
    localparam int LB_DEPTH = CW / 2;
    localparam int COL_W    = (CW > 1) ? $clog2(CW) : 1;
    localparam int ROW_W    = (CH > 1) ? $clog2(CH) : 1;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam bit CW_ODD   = (CW % 2) == 1;
    localparam bit CH_ODD   = (CH % 2) == 1;

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(CW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(CH - 1);
    localparam logic [ROW_W-1:0] ROW_PRE_LAST = ROW_W'(CH - 2);

    typedef logic signed [RES_W-1:0] res_t;

    function automatic res_t smax(input res_t a, input res_t b);
        return (a > b) ? a : b;
    endfunction

    pool_state_t       r_state;
    pool_state_t       w_state_next;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    res_t              r_pair;
    res_t              r_pool_data;
    logic              r_pool_valid;
    logic              r_frame_done;
    logic [15:0]       r_pool_count;

    res_t              w_in;
    res_t              w_pair_max;
    res_t              w_lb_rdata;
    logic [RES_W-1:0]  w_lb_rdata_raw;
    logic [LB_AW-1:0]  w_lb_addr;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_pair_lo;
    logic              w_lb_we;
    logic              w_lb_re;
    logic              w_emit;
    logic              w_frame_end;

`ifdef POOL_RELU_EN
    assign w_in = pool_if.in_data[RES_W-1] ? res_t'(0) : pool_if.in_data;
`else
    assign w_in = pool_if.in_data;
`endif

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_pair_max = smax(r_pair, w_in);
    assign w_lb_addr  = LB_AW'(r_col >> 1);
    assign w_lb_rdata = w_lb_rdata_raw;
    // Even column opens a pair, except the unpaired last column of an odd-width map.
    assign w_pair_lo  = pool_if.in_valid && !r_col[0] && !(CW_ODD && w_col_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EVEN_ROW;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_lb_we      = 1'b0;
        w_lb_re      = 1'b0;
        w_emit       = 1'b0;
        w_frame_end  = 1'b0;
        if (pool_if.in_valid) begin
            // Read one column early so the registered data meets the odd column.
            w_lb_re = w_pair_lo && (r_state == ODD_ROW);
            if (r_col[0]) begin
                w_lb_we = (r_state == EVEN_ROW);
                w_emit  = (r_state == ODD_ROW);
            end
            if (w_col_last) begin
                if (w_row_last) begin
                    w_frame_end  = 1'b1;
                    w_state_next = EVEN_ROW;
                end else begin
                    case (r_state)
                        EVEN_ROW: w_state_next = ODD_ROW;
                        ODD_ROW:  w_state_next = (CH_ODD && (r_row == ROW_PRE_LAST))
                                                 ? DROP_ROW : EVEN_ROW;
                        default:  w_state_next = EVEN_ROW;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_pair       <= '0;
            r_pool_data  <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_pool_count <= '0;
        end else begin
            r_pool_valid <= w_emit;
            r_frame_done <= w_frame_end;
            // Count restarts the cycle after frame_done; an emit there still counts.
            r_pool_count <= (r_frame_done ? 16'd0 : r_pool_count) + {15'd0, w_emit};
            if (w_emit) begin
                r_pool_data <= smax(w_lb_rdata, w_pair_max);
            end
            if (w_pair_lo) begin
                r_pair <= w_in;
            end
            if (pool_if.in_valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    pool_linebuf #(
        .WIDTH (RES_W),
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_lb_we),
        .i_re    (w_lb_re),
        .i_addr  (w_lb_addr),
        .i_wdata (w_pair_max),
        .o_rdata (w_lb_rdata_raw)
    );

    assign pool_if.pool_valid = r_pool_valid;
    assign pool_if.pool_data  = r_pool_data;
    assign pool_if.frame_done = r_frame_done;
    assign pool_if.pool_count = r_pool_count;
endmodule

// File: tb/tb_conv_maxpool2x2.sv
// -----------------------------------------------------------------------------
// tb_conv_maxpool2x2
// Directed bench: a 4x4 conv map instance (IMG 5x5) and a 5x5 conv map
// instance (IMG 6x6). Each frame is a stimulus list plus the input indices
// that must trigger a pooled output and the hand-computed pooled values.
// -----------------------------------------------------------------------------
module tb_conv_maxpool2x2;
    import systolic_pkg::*;

    localparam int DS = 8;
    localparam int RW = calc_res_w(DS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_maxpool2x2_if #(.RES_W(RW)) if4 ();
    conv_maxpool2x2_if #(.RES_W(RW)) if5 ();

    conv_maxpool2x2 #(.dataSize(DS), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut4 (
        .clk(clk), .rst(rst), .pool_if(if4)
    );
    conv_maxpool2x2 #(.dataSize(DS), .IMG_WIDTH(6), .IMG_HEIGHT(6)) dut5 (
        .clk(clk), .rst(rst), .pool_if(if5)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int o_pv, o_pd, o_fd, o_cnt;
    int stim[$];
    int trig[$];
    int expv[$];

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle on the selected instance, then capture its outputs.
    task automatic step(input int sel, input bit v, input int d);
        if (sel == 0) begin
            if4.in_valid = v;
            if4.in_data  = RW'(d);
        end else begin
            if5.in_valid = v;
            if5.in_data  = RW'(d);
        end
        @(posedge clk);
        #1;
        if (sel == 0) begin
            o_pv  = int'(if4.pool_valid);
            o_pd  = int'(if4.pool_data);
            o_fd  = int'(if4.frame_done);
            o_cnt = int'(if4.pool_count);
        end else begin
            o_pv  = int'(if5.pool_valid);
            o_pd  = int'(if5.pool_data);
            o_fd  = int'(if5.frame_done);
            o_cnt = int'(if5.pool_count);
        end
    endtask

    task automatic fill_seq(input int first, input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(first + i);
    endtask

    task automatic run_frame(input int sel, input string tag, input int n_send,
                             input bit gaps, input int drop_idx);
        int k;
        int last;
        k    = 0;
        last = stim.size() - 1;
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                for (int j = 0; j < g; j++) begin
                    step(sel, 1'b0, 0);
                    check_val({tag, "_gap_pv"}, o_pv, 0);
                end
            end
            step(sel, 1'b1, stim[i]);
            if (k < trig.size() && trig[k] == i) begin
                check_val({tag, "_pv"}, o_pv, 1);
                check_val({tag, "_pd"}, o_pd, expv[k]);
                k++;
            end else begin
                check_val({tag, "_pv"}, o_pv, 0);
            end
            check_val({tag, "_fd"}, o_fd, (i == last) ? 1 : 0);
            if (i == drop_idx)
                check_val({tag, "_drop_state"}, int'(dut5.r_state), int'(DROP_ROW));
            if (i == last)
                check_val({tag, "_cnt"}, o_cnt, trig.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        if4.in_valid = 1'b0; if4.in_data = '0;
        if5.in_valid = 1'b0; if5.in_data = '0;
        step(0, 1'b0, 0);
        step(0, 1'b0, 0);
        check_val("rst_pv", o_pv, 0);
        check_val("rst_pd", o_pd, 0);
        check_val("rst_fd", o_fd, 0);
        check_val("rst_cnt", o_cnt, 0);
        step(1, 1'b0, 0);
        check_val("rst5_pv", o_pv, 0);
        check_val("rst5_cnt", o_cnt, 0);
        rst = 1'b0;

        // 4x4 map 1..16, contiguous
        fill_seq(1, 16);
        trig = '{5, 7, 13, 15};
        expv = '{6, 8, 14, 16};
        run_frame(0, "t1", 16, 1'b0, -1);
        step(0, 1'b0, 0);
        check_val("t1_cnt_clr", o_cnt, 0);
        check_val("t1_fd_clr", o_fd, 0);

        // same frame with random idle gaps
        run_frame(0, "t2", 16, 1'b1, -1);
        step(0, 1'b0, 0);

        // negative map, -2 at (1,1)
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(-5);
        stim[5] = -2;
`ifdef POOL_RELU_EN
        expv = '{0, 0, 0, 0};
`else
        expv = '{-2, -5, -5, -5};
`endif
        run_frame(0, "t3", 16, 1'b0, -1);
        step(0, 1'b0, 0);

        // mixed signs in tile (0,1): -1, 3, -7, 1 -> 3 with or without ReLU
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(0);
        stim[2] = -1; stim[3] = 3; stim[6] = -7; stim[7] = 1;
        expv = '{0, 3, 0, 0};
        run_frame(0, "t3b", 16, 1'b0, -1);
        step(0, 1'b0, 0);

        // 5x5 map 1..25, odd dims, DROP_ROW on row 4
        fill_seq(1, 25);
        trig = '{6, 8, 16, 18};
        expv = '{7, 9, 17, 19};
        run_frame(1, "t4", 25, 1'b0, 20);
        step(1, 1'b0, 0);
        check_val("t4_cnt_clr", o_cnt, 0);

        // back-to-back 4x4 frames
        fill_seq(1, 16);
        trig = '{5, 7, 13, 15};
        expv = '{6, 8, 14, 16};
        run_frame(0, "t5a", 16, 1'b0, -1);
        fill_seq(17, 16);
        expv = '{22, 24, 30, 32};
        run_frame(0, "t5b", 16, 1'b0, -1);
        step(0, 1'b0, 0);

        // reset after 7 inputs, then a fresh frame
        fill_seq(1, 16);
        expv = '{6, 8, 14, 16};
        run_frame(0, "t6a", 7, 1'b0, -1);
        rst = 1'b1;
        step(0, 1'b1, 8);
        check_val("t6_rst_pv", o_pv, 0);
        step(0, 1'b1, 9);
        check_val("t6_rst_pv2", o_pv, 0);
        check_val("t6_rst_cnt", o_cnt, 0);
        rst = 1'b0;
        step(0, 1'b0, 0);
        check_val("t6_post_pv", o_pv, 0);
        run_frame(0, "t6b", 16, 1'b0, -1);
        step(0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
